// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start, NB_DATA data bits LSB-first, optional parity, NB_STOP stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (PARITY_ODD selects odd/even).
module uart_tx_cfg #(
    parameter int NB_DATA         = 8,
    parameter int NB_STOP         = 1,
    parameter int OVERSAMPLE      = 16,
    parameter int PARITY_ODD      = 0,
    parameter int NB_TICK_COUNTER = $clog2(OVERSAMPLE * NB_STOP),
    parameter int NB_BIT_COUNTER  = $clog2(NB_DATA)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_data,
    output logic               o_busy,
    output logic               o_done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;
`endif

    localparam logic [NB_TICK_COUNTER-1:0] TICK_BIT_LAST  = NB_TICK_COUNTER'(OVERSAMPLE - 1);
    localparam logic [NB_TICK_COUNTER-1:0] TICK_STOP_LAST = NB_TICK_COUNTER'(OVERSAMPLE * NB_STOP - 1);
    localparam logic [NB_BIT_COUNTER-1:0]  BIT_LAST       = NB_BIT_COUNTER'(NB_DATA - 1);

    state_t                     state, state_next;
    logic [NB_TICK_COUNTER-1:0] tick_cnt, tick_next;
    logic [NB_BIT_COUNTER-1:0]  bit_cnt, bit_next;
    logic [NB_DATA-1:0]         shift_reg, shift_next;
    logic                       data_next, ready_next, busy_next, done_next;
    logic                       bit_end;
`ifdef UART_TX_PARITY_EN
    logic                       parity_bit, parity_next;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '1;
            o_data    <= 1'b1;
            o_ready   <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            o_data    <= data_next;
            o_ready   <= ready_next;
            o_busy    <= busy_next;
            o_done    <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    assign bit_end = i_tick && (tick_cnt == TICK_BIT_LAST);

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        data_next  = o_data;
        ready_next = o_ready;
        busy_next  = o_busy;
        done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif
        case (state)
            IDLE: begin
                data_next  = 1'b1;
                ready_next = 1'b1;
                busy_next  = 1'b0;
                tick_next  = '0;
                bit_next   = '0;
                if (i_valid && o_ready) begin
                    shift_next = i_data;
`ifdef UART_TX_PARITY_EN
                    parity_next = (^i_data) ^ (PARITY_ODD != 0);
`endif
                    state_next = START;
                    data_next  = 1'b0;
                    ready_next = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    tick_next  = '0;
                    state_next = DATA;
                    data_next  = shift_reg[0];
                end else if (i_tick) begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tick_next  = '0;
                    shift_next = {1'b1, shift_reg[NB_DATA-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        bit_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        data_next  = parity_bit;
`else
                        state_next = STOP;
                        data_next  = 1'b1;
`endif
                    end else begin
                        bit_next  = bit_cnt + 1'b1;
                        data_next = shift_reg[1];
                    end
                end else if (i_tick) begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tick_next  = '0;
                    state_next = STOP;
                    data_next  = 1'b1;
                end else if (i_tick) begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (i_tick) begin
                    if (tick_cnt == TICK_STOP_LAST) begin
                        tick_next  = '0;
                        state_next = IDLE;
                        done_next  = 1'b1;
                        ready_next = 1'b1;
                        busy_next  = 1'b0;
                        data_next  = 1'b1;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tick_next  = '0;
                bit_next   = '0;
                shift_next = '1;
                data_next  = 1'b1;
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8N1, back-to-back, ignored valid, async reset, 7N2 and parity frames.
module tb_uart_tx_cfg;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;

    logic [7:0] data_a = '0;
    logic       valid_a = 1'b0;
    logic       ready_a, line_a, busy_a, done_a;
    logic [6:0] data_b = '0;
    logic       valid_b = 1'b0;
    logic       ready_b, line_b, busy_b, done_b;
    logic [7:0] data_c = '0;
    logic       valid_c = 1'b0;
    logic       ready_c, line_c, busy_c, done_c;

    int n_checks = 0;
    int n_pass = 0;

    uart_tx_cfg u_dut_a (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data_a), .i_valid(valid_a),
        .o_ready(ready_a), .o_data(line_a), .o_busy(busy_a), .o_done(done_a)
    );

    uart_tx_cfg #(.NB_DATA(7), .NB_STOP(2)) u_dut_b (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data_b), .i_valid(valid_b),
        .o_ready(ready_b), .o_data(line_b), .o_busy(busy_b), .o_done(done_b)
    );

    uart_tx_cfg #(.PARITY_ODD(1)) u_dut_c (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data_c), .i_valid(valid_c),
        .o_ready(ready_c), .o_data(line_c), .o_busy(busy_c), .o_done(done_c)
    );

    always #5 clk = ~clk;

    // One-clock tick every 4 clocks, changed just after the rising edge.
    initial begin
        int c = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = (c % 4 == 3);
            c++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic line_of(input int sel);
        case (sel)
            0: return line_a;
            1: return line_b;
            default: return line_c;
        endcase
    endfunction

    function automatic logic ready_of(input int sel);
        case (sel)
            0: return ready_a;
            1: return ready_b;
            default: return ready_c;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic send(input int sel, input logic [8:0] w);
        case (sel)
            0: begin data_a = w[7:0]; valid_a = 1'b1; end
            1: begin data_b = w[6:0]; valid_b = 1'b1; end
            default: begin data_c = w[7:0]; valid_c = 1'b1; end
        endcase
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
    endtask

    // Samples each bit mid-period by counting ticks from the start bit; returns at the o_done negedge.
    task automatic capture(input int sel, input int nd, input int ns, input logic [8:0] word,
                           input logic par, input string tag);
        int ticks = 0;
        int done_at = -1;
        int nbits = 1 + nd + P + ns;
        int len = nbits * OS;
        logic [15:0] frame = '1;
        logic [8:0] got = '0;
        for (int n = 0; n < 200 && line_of(sel) !== 1'b0; n++) @(negedge clk);
        check({tag, "_busy"}, 32'(busy_of(sel)), 32'd1);
        check({tag, "_ready_low"}, 32'(ready_of(sel)), 32'd0);
        for (int n = 0; n < len * 4 + 40 && done_at < 0; n++) begin
            if (tick) begin
                ticks++;
                if (ticks % OS == OS / 2 && ticks / OS < 16) frame[ticks / OS] = line_of(sel);
            end
            if (done_of(sel)) begin
                done_at = ticks;
                check({tag, "_ready_at_done"}, 32'(ready_of(sel)), 32'd1);
                check({tag, "_busy_at_done"}, 32'(busy_of(sel)), 32'd0);
                check({tag, "_line_at_done"}, 32'(line_of(sel)), 32'd1);
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_done_tick"}, done_at, len);
        check({tag, "_start"}, 32'(frame[0]), 32'd0);
        for (int i = 0; i < nd; i++) got[i] = frame[i + 1];
        check({tag, "_data"}, 32'(got), 32'(word));
        check({tag, "_after_data"}, 32'(frame[nd + 1]), (P == 1) ? 32'(par) : 32'd1);
        for (int i = 0; i < ns; i++) check({tag, "_stop"}, 32'(frame[1 + nd + P + i]), 32'd1);
    endtask

    initial begin
        int t;
        int zeros;
        int dones;

        repeat (3) @(negedge clk);
        check("rst_line", 32'(line_a), 32'd1);
        check("rst_ready", 32'(ready_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 0x55
        send(0, 9'h055);
        capture(0, 8, 1, 9'h055, 1'b0, "t1");
        @(negedge clk);
        check("t1_done_pulse", 32'(done_a), 32'd0);
        check("t1_ready_after", 32'(ready_a), 32'd1);

        // back-to-back 0xFF then 0x00 with valid held
        data_a = 8'hFF;
        valid_a = 1'b1;
        @(negedge clk);
        data_a = 8'h00;
        capture(0, 8, 1, 9'h0FF, 1'b0, "t2a");
        @(negedge clk);
        check("t2_gap", 32'(line_a), 32'd0);
        valid_a = 1'b0;
        capture(0, 8, 1, 9'h000, 1'b0, "t2b");

        // valid pulsed mid-frame must be dropped
        send(0, 9'h0A5);
        fork
            capture(0, 8, 1, 9'h0A5, 1'b0, "t3");
            begin
                repeat (200) @(negedge clk);
                data_a = 8'h3C;
                valid_a = 1'b1;
                @(negedge clk);
                valid_a = 1'b0;
                data_a = 8'h00;
            end
        join
        zeros = 0;
        dones = 0;
        repeat (100) begin
            @(negedge clk);
            if (line_a !== 1'b1) zeros++;
            if (done_a !== 1'b0) dones++;
        end
        check("t3_no_frame", zeros, 0);
        check("t3_no_done", dones, 0);

        // async reset during data bit 3 (ticks 65..80 from start)
        send(0, 9'h000);
        t = 0;
        for (int n = 0; n < 1000 && t < 72; n++) begin
            if (tick) t++;
            if (t < 72) @(negedge clk);
        end
        check("t4_bit3_low", 32'(line_a), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("t4_rst_line", 32'(line_a), 32'd1);
        check("t4_rst_ready", 32'(ready_a), 32'd1);
        check("t4_rst_busy", 32'(busy_a), 32'd0);
        check("t4_rst_done", 32'(done_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(0, 9'h081);
        capture(0, 8, 1, 9'h081, 1'b0, "t4");

        // 7 data bits, 2 stop bits
        send(1, 9'h041);
        capture(1, 7, 2, 9'h041, 1'b0, "t5");

        // 0x07: even parity 1, odd parity 0
        @(negedge clk);
        send(0, 9'h007);
        capture(0, 8, 1, 9'h007, 1'b1, "t6_even");
        @(negedge clk);
        send(2, 9'h007);
        capture(2, 8, 1, 9'h007, 1'b0, "t6_odd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
